rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Arbitrates a single shared memory bus between the instruction-fetch (IF) port and the data-access (MEM) port of the 5-stage RV32 pipeline.
- Sequences each bus transaction with a req/ack handshake and returns read data to the winning requester.
- Generates stall signals for the IF and MEM stages, which the hazard/forwarding logic consumes.
- Priority is data-first, with a starvation guard for fetch.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width. Must be a multiple of 8.
- STARVE_MAX, 4, number of consecutive MEM grants while if_req is pending before IF is forced a grant. Range 1..15.
- TIMEOUT_CYC, 64, ack watchdog limit. Used only with RV_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request, held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction, valid while if_ready.
- if_ready  out  1  one-cycle completion pulse.
- mem_req  in  1  data request, held until mem_ready.
- mem_we  in  1  1=store, 0=load.
- mem_be  in  DATA_W/8  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data, valid while mem_ready.
- mem_ready  out  1  one-cycle completion pulse.
- bus_req  out  1  bus transaction valid.
- bus_we  out  1  bus write.
- bus_be  out  DATA_W/8  bus byte enables.
- bus_addr  out  ADDR_W  bus address.
- bus_wdata  out  DATA_W  bus write data.
- bus_ack  in  1  bus completion. bus_rdata is valid in the same cycle.
- bus_rdata  in  DATA_W  bus read data.
- stall_if  out  1  IF stage stall.
- stall_mem  out  1  MEM stage stall.
- bus_err  out  1  timeout error pulse.

Behaviour:
- Reset: synchronous on clk edge while rst_n=0. Reset state is FSM=IDLE and starve_cnt=0. All registered outputs reset to 0: bus_req, bus_we, bus_be, bus_addr, bus_wdata, if_rdata, mem_rdata, if_ready, mem_ready, bus_err.
- FSM states: IDLE, BUS_IF, BUS_MEM, DONE.
- IDLE, arbitration:
  - If mem_req=1 and (if_req=0 or starve_cnt<STARVE_MAX): go to BUS_MEM and latch the mem_* fields onto the bus_* registers.
  - Else if if_req=1: go to BUS_IF. Latch if_addr; bus_we=0; bus_be all ones; bus_wdata=0.
  - Else stay in IDLE.
- Starvation counter (starve_cnt):
  - Increments (saturating at STARVE_MAX) on each MEM grant made while if_req=1.
  - Clears on every IF grant.
  - Clears in any IDLE cycle with if_req=0.
- BUS_IF / BUS_MEM:
  - bus_req=1 and all bus_* fields are held stable until bus_ack=1.
  - On bus_ack: capture bus_rdata into if_rdata or mem_rdata, go to DONE, drop bus_req on the same edge.
  - For stores, mem_rdata is captured but is don't-care.
- DONE: exactly one cycle. The matching if_ready or mem_ready is 1. No arbitration happens in DONE; next state is IDLE. The requester must deassert or advance its req in the DONE cycle.
- Latency:
  - Request seen in IDLE at cycle N gives bus_req=1 at N+1.
  - bus_ack at cycle M gives ready=1 at M+1.
  - Minimum is 3 cycles from req to ready (ack arriving at N+1).
- Stalls (combinational): stall_if = if_req & ~if_ready; stall_mem = mem_req & ~mem_ready.
- Simultaneous events:
  - if_req and mem_req both rising in the same IDLE cycle: MEM wins unless the starvation limit has been reached.
  - bus_ack while in IDLE or DONE: ignored.
- Reset mid-transaction: bus_req=0 at the next edge. Any later bus_ack is ignored. No ready pulse is issued.
- Request inputs are sampled only in IDLE. Changes during BUS_* states are ignored.

Optional Feature:
RV_ARB_TIMEOUT_EN
- Defined:
  - An 8-bit-min wait counter clears on entry to BUS_IF/BUS_MEM and increments each cycle without bus_ack.
  - When the counter reaches TIMEOUT_CYC-1 without ack: drop bus_req and go to DONE.
  - The requester's rdata is forced to 0, its ready pulse is issued, and bus_err=1 for that same DONE cycle.
- Not defined: no counter exists, BUS_* states wait indefinitely for ack, and bus_err is tied to 0.

Test Plan:
- Lone fetch:
  - Stimulus: if_req=1, if_addr=0x100, bus_ack at 2nd bus_req cycle with bus_rdata=0x00000013.
  - Required: if_ready pulse one cycle later, if_rdata=0x00000013, stall_if high until then, bus_we=0.
- Lone store:
  - Stimulus: mem_req=1, mem_we=1, mem_be=4'b0011, mem_addr=0x2000, mem_wdata=0xDEADBEEF.
  - Required: bus fields match exactly while bus_req=1; mem_ready one cycle after ack.
- Same-cycle conflict:
  - Stimulus: if_req and mem_req asserted together in IDLE.
  - Required: BUS_MEM is granted first; IF is granted right after the DONE/IDLE sequence.
- Starvation:
  - Stimulus: if_req held high, mem_req re-asserted back-to-back, STARVE_MAX=4.
  - Required: 4 MEM transactions, then 1 IF transaction, then MEM resumes.
- Reset mid-transaction:
  - Stimulus: rst_n=0 while BUS_MEM is waiting, then bus_ack pulsed after reset releases.
  - Required: bus_req=0 next edge, no mem_ready, FSM in IDLE.
- Timeout (RV_ARB_TIMEOUT_EN, TIMEOUT_CYC=8):
  - Stimulus: load with bus_ack never asserted.
  - Required: bus_req high for 8 cycles, then mem_ready=1, bus_err=1, mem_rdata=0.

Source files
------------

// File: rtl/rv_mem_arbiter.sv
// Shared memory bus arbiter for the RV32 IF and MEM ports: data-first priority with a fetch starvation guard.
// Defining RV_ARB_TIMEOUT_EN adds an ack watchdog that completes a hung transaction with bus_err.
module rv_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_be,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ready,
    output logic                bus_req,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                bus_err
);

    // state   | meaning
    // IDLE    | arbitrate between if_req and mem_req
    // BUS_IF  | fetch transaction on the bus, waiting for ack
    // BUS_MEM | data transaction on the bus, waiting for ack
    // DONE    | one-cycle ready pulse to the served requester
    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_MEM,
        DONE
    } state_e;

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    if ((DATA_W % 8) != 0 || STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("rv_mem_arbiter: illegal parameter combination");
    end

    state_e              state_q, state_d;
    logic [3:0]          starve_q, starve_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [BE_W-1:0]     bus_be_q, bus_be_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;

`ifdef RV_ARB_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                bus_err_q, bus_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_be_d    = bus_be_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
`ifdef RV_ARB_TIMEOUT_EN
        wait_d      = wait_q;
        bus_err_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
`ifdef RV_ARB_TIMEOUT_EN
                wait_d = '0;
`endif
                if (mem_req && (!if_req || starve_q < STARVE_LIM)) begin
                    state_d     = BUS_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_be_d    = mem_be;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    // With fetch waiting this branch implies starve_q < limit, so +1 saturates by construction.
                    starve_d    = if_req ? starve_q + 4'd1 : 4'd0;
                end else if (if_req) begin
                    state_d     = BUS_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_be_d    = '1;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    starve_d    = 4'd0;
                end else begin
                    starve_d    = 4'd0;
                end
            end
            BUS_IF, BUS_MEM: begin
                if (bus_ack) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    if (state_q == BUS_IF) begin
                        if_rdata_d = bus_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        mem_rdata_d = bus_rdata;
                        mem_ready_d = 1'b1;
                    end
                end
`ifdef RV_ARB_TIMEOUT_EN
                else if (wait_q == WAIT_LAST) begin
                    state_d   = DONE;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == BUS_IF) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        mem_rdata_d = '0;
                        mem_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
`ifdef RV_ARB_TIMEOUT_EN
            wait_q      <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_be_q    <= bus_be_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
`ifdef RV_ARB_TIMEOUT_EN
            wait_q      <= wait_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_ready  = if_ready_q;
    assign mem_ready = mem_ready_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = mem_req & ~mem_ready_q;

`ifdef RV_ARB_TIMEOUT_EN
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Bench for rv_mem_arbiter: directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_rv_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 4;
    localparam int TO   = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_req;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          bus_req;
    logic          bus_we;
    logic [BW-1:0] bus_be;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;
    logic          stall_if;
    logic          stall_mem;
    logic          bus_err;

    always #5 clk = ~clk;

    rv_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction is granted when the arbiter is free, served until ack
    // (or watchdog), followed by one ready cycle and one free cycle before the next grant.
    bit            m_busy, m_acked, m_is_mem;
    int            m_streak, m_wait;
    bit            e_bus_req, e_if_ready, e_mem_ready, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_if_rdata, e_mem_rdata;
    logic          e_we;
    logic [BW-1:0] e_be;

    task automatic model_step();
        e_if_ready  = 0;
        e_mem_ready = 0;
        e_err       = 0;
        if (!rst_n) begin
            m_busy = 0; m_acked = 0; m_streak = 0; m_wait = 0;
            e_bus_req = 0; e_if_rdata = '0; e_mem_rdata = '0;
        end else if (!m_busy) begin
            if (mem_req && (!if_req || m_streak < SMAX)) begin
                m_busy = 1; m_is_mem = 1; m_wait = 0; e_bus_req = 1;
                e_addr = mem_addr; e_we = mem_we; e_be = mem_be; e_wdata = mem_wdata;
                m_streak = if_req ? m_streak + 1 : 0;
            end else if (if_req) begin
                m_busy = 1; m_is_mem = 0; m_wait = 0; e_bus_req = 1;
                e_addr = if_addr; e_we = 0; e_be = '1; e_wdata = '0;
                m_streak = 0;
            end else begin
                m_streak = 0;
            end
        end else if (m_acked) begin
            m_busy = 0; m_acked = 0;
        end else if (bus_ack) begin
            m_acked = 1; e_bus_req = 0;
            if (m_is_mem) begin e_mem_rdata = bus_rdata; e_mem_ready = 1; end
            else begin e_if_rdata = bus_rdata; e_if_ready = 1; end
        end
`ifdef RV_ARB_TIMEOUT_EN
        else if (m_wait == TO - 1) begin
            m_acked = 1; e_bus_req = 0; e_err = 1;
            if (m_is_mem) begin e_mem_rdata = '0; e_mem_ready = 1; end
            else begin e_if_rdata = '0; e_if_ready = 1; end
        end else begin
            m_wait++;
        end
`endif
    endtask

    logic [31:0] grant_log[$];
    logic        prev_bus_req;

    task automatic compare();
        check_eq("bus_req", bus_req, e_bus_req);
        if (e_bus_req) begin
            check_eq("bus_addr", bus_addr, e_addr);
            check_eq("bus_we", bus_we, e_we);
            check_eq("bus_be", bus_be, e_be);
            check_eq("bus_wdata", bus_wdata, e_wdata);
        end
        check_eq("if_ready", if_ready, e_if_ready);
        check_eq("mem_ready", mem_ready, e_mem_ready);
        if (e_if_ready) check_eq("if_rdata", if_rdata, e_if_rdata);
        if (e_mem_ready) check_eq("mem_rdata", mem_rdata, e_mem_rdata);
        check_eq("stall_if", stall_if, if_req & ~e_if_ready);
        check_eq("stall_mem", stall_mem, mem_req & ~e_mem_ready);
        check_eq("bus_err", bus_err, e_err);
        if (bus_req && !prev_bus_req) grant_log.push_back(bus_addr);
        prev_bus_req = bus_req;
    endtask

    // Stimulus modes. requester: 0 drop on ready, 1 advance address on ready, 2 random.
    // responder: 0 random, 1 ack once bus age reaches fixed_lat, 2 never ack, 3 always ack.
    int          if_mode, mem_mode, resp_mode, fixed_lat, bus_age;
    logic [31:0] fixed_rdata;

    task automatic drive_bus();
        if (e_bus_req) bus_age++; else bus_age = 0;
        bus_rdata = (resp_mode == 1) ? fixed_rdata : $urandom;
        case (resp_mode)
            0: bus_ack = e_bus_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            1: bus_ack = e_bus_req && (bus_age >= fixed_lat);
            2: bus_ack = 1'b0;
            default: bus_ack = 1'b1;
        endcase
    endtask

    task automatic drive_req();
        if (if_mode == 2) begin
            if (e_if_ready || (!if_req && $urandom_range(0, 3) == 0)) begin
                if_req  = e_if_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if_addr = $urandom & 32'hFFFF_FFFC;
            end
        end else if (e_if_ready) begin
            if_req = 1'b0;
        end
        if (mem_mode == 2) begin
            if (e_mem_ready || (!mem_req && $urandom_range(0, 3) == 0)) begin
                mem_req   = e_mem_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_be    = 4'($urandom_range(0, 15));
                mem_addr  = $urandom;
                mem_wdata = $urandom;
            end
        end else if (e_mem_ready) begin
            if (mem_mode == 1) mem_addr = mem_addr + 32'd4;
            else mem_req = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        @(negedge clk);
        drive_bus();
        drive_req();
    endtask

    task automatic wait_ready(input bit want_mem, output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(want_mem ? mem_ready : if_ready) && lat < 40);
    endtask

    task automatic settle();
        int n;
        if_mode = 0; mem_mode = 0; resp_mode = 1; fixed_lat = 1;
        n = 0;
        while ((if_req || mem_req || m_busy) && n < 60) begin
            tick();
            n++;
        end
        check_eq("settle_quiet", {30'd0, if_req, mem_req}, 32'd0);
        tick();
        tick();
    endtask

    function automatic logic [31:0] logged(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 32'hEEEE_EEEE;
    endfunction

    logic [31:0] exp_seq[6];
    int          lat, n, cnt;

    initial begin
        rst_n = 0; if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_be = '0;
        mem_addr = '0; mem_wdata = '0; bus_ack = 0; bus_rdata = '0;
        if_mode = 0; mem_mode = 0; resp_mode = 1; fixed_lat = 2; fixed_rdata = '0; bus_age = 0;
        prev_bus_req = 0; m_busy = 0; m_acked = 0; m_is_mem = 0; m_streak = 0; m_wait = 0;
        e_bus_req = 0; e_if_ready = 0; e_mem_ready = 0; e_err = 0;
        e_addr = '0; e_we = 0; e_be = '0; e_wdata = '0; e_if_rdata = '0; e_mem_rdata = '0;
        exp_seq[0] = 32'h2000; exp_seq[1] = 32'h2004; exp_seq[2] = 32'h2008;
        exp_seq[3] = 32'h200C; exp_seq[4] = 32'h1000; exp_seq[5] = 32'h2010;

        @(negedge clk);
        tick();
        tick();
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_bus_we", bus_we, 32'd0);
        check_eq("rst_bus_be", bus_be, 32'd0);
        check_eq("rst_bus_wdata", bus_wdata, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'd0);
        rst_n = 1;
        tick();

        // lone fetch, ack in the second bus cycle
        fixed_rdata = 32'h0000_0013; fixed_lat = 2; resp_mode = 1;
        if_req = 1; if_addr = 32'h100;
        tick();
        check_eq("fetch_bus_we", bus_we, 32'd0);
        check_eq("fetch_stall", stall_if, 32'd1);
        wait_ready(1'b0, lat);
        check_eq("fetch_latency", lat + 1, 32'd3);
        check_eq("fetch_rdata", if_rdata, 32'h13);
        tick();
        tick();

        // lone store
        mem_req = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h2000; mem_wdata = 32'hDEAD_BEEF;
        tick();
        check_eq("store_addr", bus_addr, 32'h2000);
        check_eq("store_we", bus_we, 32'd1);
        check_eq("store_be", bus_be, 32'h3);
        check_eq("store_wdata", bus_wdata, 32'hDEAD_BEEF);
        wait_ready(1'b1, lat);
        check_eq("store_latency", lat + 1, 32'd3);
        settle();

        // same-cycle conflict
        grant_log.delete();
        if_req = 1; if_addr = 32'h1000;
        mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h2004;
        n = 0;
        while ((if_req || mem_req) && n < 40) begin tick(); n++; end
        check_eq("conflict_grants", grant_log.size(), 32'd2);
        check_eq("conflict_first", logged(0), 32'h2004);
        check_eq("conflict_second", logged(1), 32'h1000);
        settle();

        // starvation guard: fetch held while data requests stream back-to-back
        grant_log.delete();
        if_req = 1; if_addr = 32'h1000;
        mem_mode = 1; mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h2000;
        n = 0;
        while (grant_log.size() < 6 && n < 100) begin tick(); n++; end
        for (int i = 0; i < 6; i++) check_eq($sformatf("starve_seq%0d", i), logged(i), exp_seq[i]);
        settle();

        // reset while a load waits for ack, then a late ack
        mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h3000; resp_mode = 2;
        tick();
        tick();
        check_eq("rst_mid_pre", bus_req, 32'd1);
        rst_n = 0; mem_req = 0;
        tick();
        check_eq("rst_mid_bus_req", bus_req, 32'd0);
        rst_n = 1; resp_mode = 3;
        cnt = 0;
        repeat (5) begin tick(); cnt += int'(mem_ready); end
        check_eq("rst_mid_no_ready", cnt, 32'd0);
        resp_mode = 1; fixed_lat = 1;
        mem_req = 1; mem_addr = 32'h3004;
        wait_ready(1'b1, lat);
        check_eq("post_rst_latency", lat, 32'd2);
        settle();

`ifdef RV_ARB_TIMEOUT_EN
        mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h4000; resp_mode = 2;
        n = 0; cnt = 0;
        while (!mem_ready && n < 40) begin tick(); n++; cnt += int'(bus_req); end
        check_eq("timeout_bus_cycles", cnt, 32'd8);
        check_eq("timeout_ready", mem_ready, 32'd1);
        check_eq("timeout_err", bus_err, 32'd1);
        check_eq("timeout_rdata", mem_rdata, 32'd0);
`else
        mem_req = 1; mem_we = 0; mem_be = 4'hF; mem_addr = 32'h4000; resp_mode = 2;
        repeat (20) tick();
        check_eq("no_timeout_hold", bus_req, 32'd1);
        resp_mode = 3;
        wait_ready(1'b1, lat);
        check_eq("late_ack_ready", mem_ready, 32'd1);
`endif
        settle();

        if_mode = 2; mem_mode = 2; resp_mode = 0;
        repeat (3000) begin
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst_n = 1;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
